// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU: word/register widths, the
// execute-to-memory pipeline entry and the EX/MEM buffer occupancy states.
package cpu_types_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    word_t    alu;
    word_t    store_dat;
    regbits_t wsel;
    logic     regwr;
    logic     memren;
    logic     memwen;
    logic     zero;
    logic     negative;
  } ex_mem_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} exmem_state_t;

endpackage

// File: rtl/ex_mem_buffer_if.sv
// Execute-to-memory channel: valid/ready entry from the ALU side and the
// head entry presented to the memory stage.
interface ex_mem_buffer_if;
  import cpu_types_pkg::*;

  // Execute side
  logic     in_valid;
  logic     in_ready;
  word_t    alu_out;
  logic     zero_flag;
  logic     negative_flag;
  logic     overflow_flag;
  word_t    store_dat;
  regbits_t wsel;
  logic     regwr;
  logic     memren;
  logic     memwen;
  logic     trap_en;
  logic     flush;

  // Memory side
  logic     out_valid;
  logic     out_ready;
  word_t    out_alu;
  word_t    out_store_dat;
  regbits_t out_wsel;
  logic     out_regwr;
  logic     out_memren;
  logic     out_memwen;
  logic     out_zero;
  logic     out_negative;

  // The pipeline around the buffer: drives execute-side inputs and out_ready
  modport master (
    output in_valid, alu_out, zero_flag, negative_flag, overflow_flag, store_dat, wsel,
           regwr, memren, memwen, trap_en, flush, out_ready,
    input  in_ready, out_valid, out_alu, out_store_dat, out_wsel, out_regwr, out_memren,
           out_memwen, out_zero, out_negative
  );

  // The buffer itself
  modport slave (
    input  in_valid, alu_out, zero_flag, negative_flag, overflow_flag, store_dat, wsel,
           regwr, memren, memwen, trap_en, flush, out_ready,
    output in_ready, out_valid, out_alu, out_store_dat, out_wsel, out_regwr, out_memren,
           out_memwen, out_zero, out_negative
  );

endinterface

// File: rtl/ex_mem_buffer.sv
// Two-entry EX/MEM skid buffer. Trap-enabled ALU overflows are stored with
// their side effects suppressed, pulse ovf_trap and bump a saturating counter.
module ex_mem_buffer
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  ex_mem_buffer_if.slave   bus,
  output logic             ovf_trap,
  output logic [CNT_W-1:0] ovf_count
);

  exmem_state_t     state_q, state_d;
  ex_mem_t          main_q, main_d;
  ex_mem_t          skid_q, skid_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic    accept, pop, trap_take;
  ex_mem_t in_entry;

  assign accept    = bus.in_valid & bus.in_ready;
  assign pop       = bus.out_valid & bus.out_ready;
  assign trap_take = accept & bus.overflow_flag & bus.trap_en & ~bus.flush;

  // A trapped op keeps its result for visibility but must not write anything
  always_comb begin
    in_entry.alu       = bus.alu_out;
    in_entry.store_dat = bus.store_dat;
    in_entry.wsel      = bus.wsel;
    in_entry.zero      = bus.zero_flag;
    in_entry.negative  = bus.negative_flag;
    in_entry.regwr     = bus.regwr;
    in_entry.memren    = bus.memren;
    in_entry.memwen    = bus.memwen;
    if (bus.overflow_flag && bus.trap_en) begin
      in_entry.regwr  = 1'b0;
      in_entry.memren = 1'b0;
      in_entry.memwen = 1'b0;
    end
  end

  // State and storage registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      trap_q  <= trap_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and entry movement
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_d  = in_entry;
          end
        end
        HALF: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = HALF;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    trap_d = trap_take;
    cnt_d  = cnt_q;
    if (trap_take && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs depend on registered state only, so out_ready never reaches in_ready
  always_comb begin
    bus.in_ready      = (state_q != FULL);
    bus.out_valid     = (state_q != EMPTY);
    bus.out_alu       = main_q.alu;
    bus.out_store_dat = main_q.store_dat;
    bus.out_wsel      = main_q.wsel;
    bus.out_regwr     = main_q.regwr;
    bus.out_memren    = main_q.memren;
    bus.out_memwen    = main_q.memwen;
    bus.out_zero      = main_q.zero;
    bus.out_negative  = main_q.negative;
    ovf_trap          = trap_q;
    ovf_count         = cnt_q;
  end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed self-checking bench for ex_mem_buffer: streaming, backpressure,
// flush, overflow trapping, counter saturation and asynchronous reset.
module tb_ex_mem_buffer;
  import cpu_types_pkg::*;

  logic       clk;
  logic       rst;
  logic       ovf_trap;
  logic [7:0] ovf_count;
  int         checks;
  int         errors;

  ex_mem_buffer_if bus ();

  ex_mem_buffer #(
    .CNT_W(8)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .bus      (bus),
    .ovf_trap (ovf_trap),
    .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input word_t a, input logic ovf, input logic ten,
                       input logic rw);
    bus.in_valid      = v;
    bus.alu_out       = a;
    bus.store_dat     = ~a;
    bus.wsel          = a[4:0];
    bus.zero_flag     = (a == 32'h0);
    bus.negative_flag = a[31];
    bus.overflow_flag = ovf;
    bus.trap_en       = ten;
    bus.regwr         = rw;
    bus.memwen        = rw;
    bus.memren        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    checks++;
    if (bus.out_alu !== 32'h0 || bus.out_regwr !== 1'b0) begin
      errors++; $display("FAIL reset_fields got alu=%h regwr=%b want 0/0", bus.out_alu,
                         bus.out_regwr);
    end
    checks++;
    if (ovf_count !== 8'd0 || ovf_trap !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got cnt=%0d trap=%b want 0/0", ovf_count, ovf_trap);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    word_t exp_alu [3];
    exp_alu[0] = 32'h1; exp_alu[1] = 32'h2; exp_alu[2] = 32'h3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, exp_alu[i], 1'b0, 1'b0, 1'b1);
      tick();
      if (i == 2) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_alu !== exp_alu[i]) begin
        errors++; $display("FAIL stream_data[%0d] got v=%b alu=%h want 1/%h", i, bus.out_valid,
                           bus.out_alu, exp_alu[i]);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, bus.in_ready);
      end
    end
    checks++;
    if (bus.out_store_dat !== 32'hFFFF_FFFC || bus.out_wsel !== 5'd3 || bus.out_negative !== 1'b0)
    begin
      errors++; $display("FAIL stream_fields got sd=%h wsel=%0d neg=%b want fffffffc/3/0",
                         bus.out_store_dat, bus.out_wsel, bus.out_negative);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_alu !== 32'hA) begin
      errors++; $display("FAIL bp_full got rdy=%b alu=%h want 0/a", bus.in_ready, bus.out_alu);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'hA || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got v=%b alu=%h rdy=%b want 1/a/0", bus.out_valid,
                         bus.out_alu, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'hB || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%b alu=%h rdy=%b want 1/b/1", bus.out_valid,
                         bus.out_alu, bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_c got v=%b alu=%h want v=0", bus.out_valid, bus.out_alu);
    end
    // Trapping op dropped by flush must not trap or count
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || ovf_trap !== 1'b0 || ovf_count !== 8'd0) begin
      errors++; $display("FAIL flush_drop_trap got v=%b trap=%b cnt=%0d want 0/0/0",
                         bus.out_valid, ovf_trap, ovf_count);
    end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'h8000_0000 || bus.out_regwr !== 1'b0 ||
        bus.out_memwen !== 1'b0) begin
      errors++; $display("FAIL ovf_entry got v=%b alu=%h rw=%b mw=%b want 1/80000000/0/0",
                         bus.out_valid, bus.out_alu, bus.out_regwr, bus.out_memwen);
    end
    checks++;
    if (ovf_trap !== 1'b1 || ovf_count !== 8'd1) begin
      errors++; $display("FAIL ovf_pulse got trap=%b cnt=%0d want 1/1", ovf_trap, ovf_count);
    end
    tick();
    checks++;
    if (ovf_trap !== 1'b0 || ovf_count !== 8'd1) begin
      errors++; $display("FAIL ovf_pulse_end got trap=%b cnt=%0d want 0/1", ovf_trap, ovf_count);
    end
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.out_regwr !== 1'b1 || bus.out_memwen !== 1'b1 || ovf_trap !== 1'b0 ||
        ovf_count !== 8'd1) begin
      errors++; $display("FAIL ovf_untrapped got rw=%b mw=%b trap=%b cnt=%0d want 1/1/0/1",
                         bus.out_regwr, bus.out_memwen, ovf_trap, ovf_count);
    end
    tick();
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    repeat (260) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ovf_count !== 8'd255 || ovf_trap !== 1'b1) begin
      errors++; $display("FAIL sat_reach got cnt=%0d trap=%b want 255/1", ovf_count, ovf_trap);
    end
    tick();
    checks++;
    if (ovf_count !== 8'd255 || ovf_trap !== 1'b0) begin
      errors++; $display("FAIL sat_hold got cnt=%0d trap=%b want 255/0", ovf_count, ovf_trap);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_full got rdy=%b v=%b want 0/1", bus.in_ready,
                         bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || ovf_count !== 8'd0 ||
        bus.out_alu !== 32'h0) begin
      errors++; $display("FAIL rstmid_async got v=%b rdy=%b cnt=%0d alu=%h want 0/1/0/0",
                         bus.out_valid, bus.in_ready, ovf_count, bus.out_alu);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got v=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_overflow();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
